// File: rtl/pipeio_pkg.sv
// pipeio shared definitions: I/O base, word offsets of the register map,
// TCTRL bit layout and the address-decode helper.
package pipeio_pkg;

  localparam logic [23:0] IO_BASE_HI = 24'hFFFFFF;

  localparam logic [5:0] OFF_SW    = 6'd0;
  localparam logic [5:0] OFF_KEY   = 6'd1;
  localparam logic [5:0] OFF_LED   = 6'd2;
  localparam logic [5:0] OFF_HEX   = 6'd3;
  localparam logic [5:0] OFF_TCNT  = 6'd4;
  localparam logic [5:0] OFF_TCMP  = 6'd5;
  localparam logic [5:0] OFF_TCTRL = 6'd6;

  localparam int TC_EN      = 0;
  localparam int TC_AUTOCLR = 1;
  localparam int TC_MATCH   = 2;

  // Packed so that the struct maps bit-for-bit onto TCTRL[2:0].
  typedef struct packed {
    logic match;
    logic autoclr;
    logic en;
  } tctrl_t;

  function automatic logic is_io(input logic [31:0] addr);
    return addr[31:8] == IO_BASE_HI;
  endfunction

endpackage

// File: rtl/pipeio_sync.sv
// 2-flop synchroniser with a rising-edge pulse (sync vs previous sample).
// Ports: clock, reset (sync, high), d (async in), q (synced), rise (pulse).
module pipeio_sync
  import pipeio_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q;
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/pipeio.sv
// MEM-stage memory-mapped I/O: steers stores to RAM or I/O registers
// (SW, KEY, LED, HEX, optional timer) and muxes load data onto mmo.
// Ports: clock/reset, mwmem/malu/mb from EXE/MEM, ram_dout/ram_we to RAM,
// mmo to MEM/WB, sw/key pins, led/hex/tmr_irq outputs.
// Timer built only when PIPEIO_TIMER_EN is defined.
module pipeio
  import pipeio_pkg::*;
#(
  parameter int SW_W  = 10,
  parameter int KEY_W = 4,
  parameter int LED_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mwmem,
  input  logic [31:0]      malu,
  input  logic [31:0]      mb,
  input  logic [31:0]      ram_dout,
  output logic             ram_we,
  output logic [31:0]      mmo,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key,
  output logic [LED_W-1:0] led,
  output logic [31:0]      hex,
  output logic             tmr_irq
);

  logic        io_sel;
  logic        io_wr;
  logic [5:0]  woff;
  logic [31:0] io_rdata;
  logic        unused_bits;

  assign io_sel      = is_io(malu);
  assign woff        = malu[7:2];
  assign io_wr       = mwmem & io_sel;
  assign ram_we      = mwmem & ~io_sel;
  assign unused_bits = ^malu[1:0];

  logic [SW_W-1:0]  sw_s;
  logic [SW_W-1:0]  sw_rise_unused;
  logic [KEY_W-1:0] key_s_unused;
  logic [KEY_W-1:0] key_rise;

  pipeio_sync #(.W(SW_W)) u_sw_sync (
    .clock (clock),
    .reset (reset),
    .d     (sw),
    .q     (sw_s),
    .rise  (sw_rise_unused)
  );

  pipeio_sync #(.W(KEY_W)) u_key_sync (
    .clock (clock),
    .reset (reset),
    .d     (key),
    .q     (key_s_unused),
    .rise  (key_rise)
  );

  logic [KEY_W-1:0] key_q, key_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [31:0]      hex_q, hex_d;

  always_comb begin
    key_d = key_q;
    led_d = led_q;
    hex_d = hex_q;
    if (io_wr && woff == OFF_KEY) begin
      key_d = key_q & ~mb[KEY_W-1:0];
    end
    // New edges are ORed after the W1C so a capture wins.
    key_d = key_d | key_rise;
    if (io_wr && woff == OFF_LED) begin
      led_d = mb[LED_W-1:0];
    end
    if (io_wr && woff == OFF_HEX) begin
      hex_d = mb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      key_q <= '0;
      led_q <= '0;
      hex_q <= '0;
    end else begin
      key_q <= key_d;
      led_q <= led_d;
      hex_q <= hex_d;
    end
  end

  assign led = led_q;
  assign hex = hex_q;

`ifdef PIPEIO_TIMER_EN
  logic [31:0] tcnt_q, tcnt_d;
  logic [31:0] tcmp_q, tcmp_d;
  tctrl_t      tctrl_q, tctrl_d;
  logic        hit;

  assign hit = tctrl_q.en && (tcnt_q == tcmp_q);

  always_comb begin
    tcnt_d  = tcnt_q;
    tcmp_d  = tcmp_q;
    tctrl_d = tctrl_q;
    if (tctrl_q.en) begin
      tcnt_d = (hit && tctrl_q.autoclr) ? 32'd0 : tcnt_q + 32'd1;
    end
    // CPU write of TCNT overrides count/auto-clear.
    if (io_wr && woff == OFF_TCNT) begin
      tcnt_d = mb;
    end
    if (io_wr && woff == OFF_TCMP) begin
      tcmp_d = mb;
    end
    if (io_wr && woff == OFF_TCTRL) begin
      tctrl_d.en      = mb[TC_EN];
      tctrl_d.autoclr = mb[TC_AUTOCLR];
      if (mb[TC_MATCH]) begin
        tctrl_d.match = 1'b0;
      end
    end
    // Match set applied last so it beats a same-cycle W1C.
    if (hit) begin
      tctrl_d.match = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tcnt_q  <= '0;
      tcmp_q  <= '0;
      tctrl_q <= '0;
    end else begin
      tcnt_q  <= tcnt_d;
      tcmp_q  <= tcmp_d;
      tctrl_q <= tctrl_d;
    end
  end

  assign tmr_irq = tctrl_q.match;
`else
  assign tmr_irq = 1'b0;
`endif

  always_comb begin
    io_rdata = '0;
    unique case (1'b1)
      (woff == OFF_SW):    io_rdata[SW_W-1:0]  = sw_s;
      (woff == OFF_KEY):   io_rdata[KEY_W-1:0] = key_q;
      (woff == OFF_LED):   io_rdata[LED_W-1:0] = led_q;
      (woff == OFF_HEX):   io_rdata            = hex_q;
`ifdef PIPEIO_TIMER_EN
      (woff == OFF_TCNT):  io_rdata            = tcnt_q;
      (woff == OFF_TCMP):  io_rdata            = tcmp_q;
      (woff == OFF_TCTRL): io_rdata[2:0]       = tctrl_q;
`endif
      default:             io_rdata            = '0;
    endcase
  end

  assign mmo = io_sel ? io_rdata : ram_dout;

endmodule

// File: doc/pipeio.md
# pipeio

Memory-mapped I/O unit sitting directly downstream of the EXE/MEM pipeline register, in parallel with the data RAM in the MEM stage. Decodes `malu` and steers each store either to the data RAM or to a small bank of I/O registers: switches, keys, LEDs, hex display and a compare timer. Muxes the load data returned to the MEM/WB register.

## Interface
Parameters:
- `SW_W`, 10, number of switch inputs
- `KEY_W`, 4, number of push-button inputs (active-high after board inversion)
- `LED_W`, 10, number of LED outputs

Ports:
- `clock`  in  1  system clock; all registers update on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `mwmem`  in  1  MEM-stage store enable
- `malu`  in  32  MEM-stage byte address
- `mb`  in  32  MEM-stage store data
- `ram_dout`  in  32  read data from the data RAM
- `ram_we`  out  1  write enable to the data RAM
- `mmo`  out  32  load data to MEM/WB
- `sw`  in  SW_W  raw asynchronous switches
- `key`  in  KEY_W  raw asynchronous keys
- `led`  out  LED_W  LED register
- `hex`  out  32  eight 4-bit hex digits, digit 0 in [3:0]
- `tmr_irq`  out  1  timer match flag, level

## Operation
- `io_sel = (malu[31:8] == 24'hFFFFFF)`. Word offset is `malu[7:2]`; `malu[1:0]` is ignored.
- `ram_we = mwmem & ~io_sel`. I/O writes require `mwmem & io_sel` and commit on the rising edge of `clock`.
- `mmo = io_sel ? io_rdata : ram_dout`. The mux is combinational, and unused bits read 0.
- Register map (offset: name, access):
  - 0x00 SW, RO: `sw` after a 2-flop synchroniser.
  - 0x04 KEY, R/W1C: sticky rising-edge capture per key, taken from the synchronised key versus its previous sample.
  - 0x08 LED, RW: value in [LED_W-1:0].
  - 0x0C HEX, RW: full 32 bits.
  - 0x10 TCNT, RW: timer counter.
  - 0x14 TCMP, RW: compare value.
  - 0x18 TCTRL:
    - bit0 EN, RW
    - bit1 AUTOCLR, RW
    - bit2 MATCH, R/W1C
  - Unmapped offsets read 0 and ignore writes.
- Timer:
  - When EN=1, TCNT increments by 1 each cycle and wraps from 0xFFFFFFFF to 0.
  - When EN=1 and TCNT==TCMP, MATCH sets on the next edge. With AUTOCLR=1, the next TCNT is 0 instead of TCNT+1.
  - `tmr_irq = MATCH`.
- Simultaneous events:
  - A CPU write to TCNT beats increment or auto-clear.
  - A hardware set of MATCH or a KEY bit beats a W1C in the same cycle.
  - Writing TCTRL updates EN and AUTOCLR only. Bit2 of the write data is the W1C.

## Timing
- Reset values: all registers are 0, so `led`=0, `hex`=0, `tmr_irq`=0. Synchroniser and edge flops are cleared.
- Reset asserted mid-operation clears state at the next edge, and any pending `mwmem` is discarded.
- Load latency is zero cycles: `mmo` is valid in the same cycle `malu` is presented, matching the RAM, which reads on the inverted clock.
- A store to LED, HEX or TCNT is visible on the output or readable in the next cycle.
- SW reflects a pin change after 2–3 edges. A key press sets its KEY bit on the 3rd edge after the rising transition.
- MATCH asserts one cycle after the cycle in which TCNT==TCMP.

## Configuration
- `PIPEIO_TIMER_EN` defined: the TCNT, TCMP and TCTRL logic is built as described above.
- `PIPEIO_TIMER_EN` not defined: no timer flops are built. Offsets 0x10–0x18 read 0, writes to them are ignored, and `tmr_irq` is tied to 0.

## Structure
- Package `pipeio_pkg` holds:
  - `IO_BASE_HI` = 24'hFFFFFF
  - word offsets `OFF_SW`, `OFF_KEY`, `OFF_LED`, `OFF_HEX`, `OFF_TCNT`, `OFF_TCMP`, `OFF_TCTRL`
  - TCTRL bit indices `TC_EN`, `TC_AUTOCLR`, `TC_MATCH`
- Sub-module `pipeio_sync` is a parameterised-width 2-flop synchroniser with a rising-edge pulse output. It is instantiated once for `sw` (edge output unused) and once for `key`.

## Test plan
- RAM/IO steering:
  - store to 0x00000010 -> `ram_we`=1 and LED unchanged.
  - store 0x3FF to 0xFFFFFF08 -> `ram_we`=0 and `led`=0x3FF on the next cycle.
  - load 0xFFFFFF08 -> `mmo`=0x3FF in the same cycle.
- Key capture: pulse `key[2]` high for 5 cycles -> KEY reads 0x4 from the 3rd edge on. Write 0x4 to 0xFFFFFF04 -> reads 0. Repeat the W1C in the same cycle as a new edge -> the bit stays 1.
- Timer match with auto-clear: TCMP=5, TCTRL=0x3 -> TCNT cycles 0..5,0. `tmr_irq` rises one cycle after TCNT==5. Write 0x4 to TCTRL -> `tmr_irq`=0.
- Timer wrap: TCNT=0xFFFFFFFE, TCMP=0, EN=1, AUTOCLR=0 -> TCNT goes 0xFFFFFFFF then 0, MATCH sets, and counting continues at 1.
- Write priority: write TCNT=0x100 while EN=1 -> the next read is 0x100, not 0x101.
- Reset mid-run: assert `reset` with timer running and LED=0x155 -> after one edge all registers and outputs are 0. Build without `PIPEIO_TIMER_EN` -> a load from 0xFFFFFF10 returns 0.
